// File: rtl/gray_ctrl_pkg.sv
// rtl/gray_ctrl_pkg.sv - shared state encoding and default width for the Gray step controller
package gray_ctrl_pkg;

    localparam int GRAY_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gray_enc.sv
// rtl/gray_enc.sv - combinational binary-to-Gray encoder
module gray_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_bin,
    output logic [N-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_step_ctrl.sv
// rtl/gray_step_ctrl.sv - steps a binary count from a start value and emits each value as registered Gray code
module gray_step_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int N = GRAY_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_steps,
    input  logic         cmd_dir,
    input  logic         hold,
    input  logic         abort,
    output logic [N-1:0] gray_out,
    output logic         gray_valid,
    output logic         busy,
    output logic         done
);

    state_t       r_state;
    logic [N-1:0] r_bin;
    logic [N-1:0] r_rem;
    logic         r_dir;
    logic [N-1:0] r_gray;
    logic         r_gray_valid;
    logic         r_done;

    logic [N-1:0] w_bin_step;
    logic [N-1:0] w_enc_in;
    logic [N-1:0] w_gray;

    assign w_bin_step = r_dir ? (r_bin + N'(1)) : (r_bin - N'(1));

    // In IDLE the encoder sees the offered start value so it can be registered on acceptance.
    assign w_enc_in = (r_state == ST_IDLE) ? cmd_start : w_bin_step;

    gray_enc #(
        .N(N)
    ) u_gray_enc (
        .i_bin  (w_enc_in),
        .o_gray (w_gray)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bin        <= '0;
            r_rem        <= '0;
            r_dir        <= 1'b0;
            r_gray       <= '0;
            r_gray_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_gray_valid <= 1'b0;
            r_done       <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            r_bin        <= cmd_start;
                            r_rem        <= cmd_steps;
                            r_dir        <= cmd_dir;
                            r_gray       <= w_gray;
                            r_gray_valid <= 1'b1;
                            r_state      <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // hold also stalls completion, so a held final code is never skipped
                        if (!hold) begin
                            if (r_rem != '0) begin
                                r_bin        <= w_bin_step;
                                r_rem        <= r_rem - N'(1);
                                r_gray       <= w_gray;
                                r_gray_valid <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE) && !abort;
    assign busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign gray_out   = r_gray;
    assign gray_valid = r_gray_valid;
    assign done       = r_done;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb/tb_gray_step_ctrl.sv - directed self-checking bench for gray_step_ctrl at N=4
module tb_gray_step_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_start;
    logic [N-1:0] cmd_steps;
    logic         cmd_dir;
    logic         hold;
    logic         abort;
    logic [N-1:0] gray_out;
    logic         gray_valid;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    gray_step_ctrl #(
        .N(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .hold       (hold),
        .abort      (abort),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (gray_valid) n_valid++;
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] g, input logic v, input logic d, input logic b);
        check_eq({tag, ".gray"},  32'(gray_out),   32'(g));
        check_eq({tag, ".valid"}, 32'(gray_valid), 32'(v));
        check_eq({tag, ".done"},  32'(done),       32'(d));
        check_eq({tag, ".busy"},  32'(busy),       32'(b));
    endtask

    task automatic start_cmd(input logic [N-1:0] s, input logic [N-1:0] n, input logic d);
        cmd_start = s;
        cmd_steps = n;
        cmd_dir   = d;
        cmd_valid = 1'b1;
        n_valid   = 0;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_steps = '0;
        cmd_dir = 1'b0; hold = 1'b0; abort = 1'b0;
        #3;
        expect_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset.ready", 32'(cmd_ready), 32'd1);

        // start 0, 3 steps up
        start_cmd(4'd0, 4'd3, 1'b1);
        expect_out("up0.t1", 4'b0000, 1'b1, 1'b0, 1'b1);
        check_eq("up0.ready_busy", 32'(cmd_ready), 32'd0);
        tick(); expect_out("up0.t2", 4'b0001, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("up0.t3", 4'b0011, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("up0.t4", 4'b0010, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("up0.t5", 4'b0010, 1'b0, 1'b1, 1'b1);
        tick(); expect_out("up0.t6", 4'b0010, 1'b0, 1'b0, 1'b0);
        check_eq("up0.ready", 32'(cmd_ready), 32'd1);
        check_eq("up0.count", 32'(n_valid), 32'd4);

        // up wrap 15 -> 0 -> 1
        start_cmd(4'd15, 4'd2, 1'b1);
        expect_out("wrapu.t1", 4'b1000, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapu.t2", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapu.t3", 4'b0001, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapu.t4", 4'b0001, 1'b0, 1'b1, 1'b1);
        tick();

        // down wrap 0 -> 15 -> 14
        start_cmd(4'd0, 4'd2, 1'b0);
        expect_out("wrapd.t1", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapd.t2", 4'b1000, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapd.t3", 4'b1001, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("wrapd.t4", 4'b1001, 1'b0, 1'b1, 1'b1);
        tick();

        // hold for two cycles after the second code
        start_cmd(4'd4, 4'd3, 1'b1);
        expect_out("hold.t1", 4'b0110, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("hold.t2", 4'b0111, 1'b1, 1'b0, 1'b1);
        hold = 1'b1;
        tick(); expect_out("hold.t3", 4'b0111, 1'b0, 1'b0, 1'b1);
        tick(); expect_out("hold.t4", 4'b0111, 1'b0, 1'b0, 1'b1);
        hold = 1'b0;
        tick(); expect_out("hold.t5", 4'b0101, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("hold.t6", 4'b0100, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("hold.t7", 4'b0100, 1'b0, 1'b1, 1'b1);
        check_eq("hold.count", 32'(n_valid), 32'd4);
        tick();

        // abort in the third RUN cycle
        start_cmd(4'd0, 4'd5, 1'b1);
        tick();
        tick(); expect_out("abort.t3", 4'b0011, 1'b1, 1'b0, 1'b1);
        abort = 1'b1;
        tick(); expect_out("abort.t4", 4'b0011, 1'b0, 1'b0, 1'b0);
        check_eq("abort.ready_masked", 32'(cmd_ready), 32'd0);
        abort = 1'b0;
        #1;
        check_eq("abort.ready", 32'(cmd_ready), 32'd1);
        tick(); expect_out("abort.t5", 4'b0011, 1'b0, 1'b0, 1'b0);

        // steps=0, with a command offered while busy
        start_cmd(4'd9, 4'd0, 1'b1);
        expect_out("single.t1", 4'b1101, 1'b1, 1'b0, 1'b1);
        cmd_start = 4'd3; cmd_steps = 4'd2; cmd_valid = 1'b1;
        tick(); expect_out("single.t2", 4'b1101, 1'b0, 1'b1, 1'b1);
        cmd_valid = 1'b0;
        tick(); expect_out("single.t3", 4'b1101, 1'b0, 1'b0, 1'b0);
        check_eq("single.count", 32'(n_valid), 32'd1);

        // asynchronous reset mid-RUN, then a fresh command
        start_cmd(4'd0, 4'd7, 1'b1);
        tick(); expect_out("rst.t2", 4'b0001, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst.async", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_cmd(4'd6, 4'd1, 1'b0);
        expect_out("rst.new1", 4'b0101, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("rst.new2", 4'b0111, 1'b1, 1'b0, 1'b1);
        tick(); expect_out("rst.new3", 4'b0111, 1'b0, 1'b1, 1'b1);
        tick(); check_eq("rst.ready", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
